adsr_envelope_multi: RTL

Multi-channel, runtime-programmable ADSR volume envelope generator. It is the successor to the fixed-time one-shot enveloper.
- NUM_CH independent channels, each with its own gate and accumulator; shared attack/decay/sustain/release configuration.
- Sits between the per-voice trigger/debounce logic and volume_adjust; one vol_out lane per voice.
- Optional one-shot mode: decay runs straight into release, with no sustain hold.

---
 rtl/env_pkg.sv | 21 ++
 rtl/env_channel.sv | 134 +++++++++++++
 rtl/adsr_envelope_multi.sv | 44 ++++
 3 files changed

// File: rtl/env_pkg.sv
// Shared types and helpers for the multi-channel ADSR envelope generator.
package env_pkg;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

  // Widest accumulator the helper supports; callers truncate to ACC_BITS.
  localparam int SUS_CALC_W = 64;

  // Left-aligns a sustain level into accumulator scale.
  function automatic logic [SUS_CALC_W-1:0] sus_acc(input logic [SUS_CALC_W-1:0] level,
                                                     input int shift);
    return level << shift;
  endfunction

endpackage

// File: rtl/env_channel.sv
// One envelope voice: gate edge capture, ADSR state machine, accumulator and done pulse.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ENV_IDLE     | silent, acc held at 0; leaves only on a captured gate edge
// ENV_ATTACK   | acc rises by attack_step per tick until full scale
// ENV_DECAY    | acc falls by decay_step per tick down to the sustain target
// ENV_SUSTAIN  | acc follows the live sustain target until gate low/retrigger
// ENV_RELEASE  | acc falls by release_step per tick to 0, then back to idle
module env_channel
  import env_pkg::*;
#(
  parameter int ACC_BITS    = 24,
  parameter int VOLUME_BITS = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tick_i,
  input  logic                   gate_i,
  input  logic                   oneshot_i,
  input  logic [ACC_BITS-1:0]    attack_step_i,
  input  logic [ACC_BITS-1:0]    decay_step_i,
  input  logic [ACC_BITS-1:0]    release_step_i,
  input  logic [VOLUME_BITS-1:0] sustain_level_i,
  output logic [VOLUME_BITS-1:0] vol_o,
  output logic                   active_o,
  output logic                   done_o
);

  localparam logic [ACC_BITS-1:0] ACC_MAX = '1;

  env_state_t          state_q, state_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic                gate_prev_q, gate_prev_d;
  logic                pend_q, pend_d;
  logic                done_q, done_d;

  logic                       rise_w;
  logic                       trig_w;
  logic [ACC_BITS-1:0]        sus_w;
  logic [ACC_BITS:0]          att_sum_w;
  logic signed [ACC_BITS:0]   dec_diff_w;
  logic                       gate_release_w;

  assign rise_w = gate_i & ~gate_prev_q;
  // An edge arriving on the very tick that would consume it still counts.
  assign trig_w = pend_q | rise_w;

  assign sus_w      = ACC_BITS'(sus_acc(SUS_CALC_W'(sustain_level_i), ACC_BITS - VOLUME_BITS));
  assign att_sum_w  = {1'b0, acc_q} + {1'b0, attack_step_i};
  assign dec_diff_w = $signed({1'b0, acc_q}) - $signed({1'b0, decay_step_i});

  assign gate_release_w = !oneshot_i && !gate_i &&
                          ((state_q == ENV_ATTACK) ||
                           (state_q == ENV_DECAY)  ||
                           (state_q == ENV_SUSTAIN));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    done_d      = 1'b0;
    gate_prev_d = gate_i;
    pend_d      = pend_q | rise_w;

    if (tick_i) begin
      pend_d = 1'b0;
      if (trig_w) begin
        // Retrigger keeps the current level so attack resumes without a click.
        state_d = ENV_ATTACK;
      end else if (gate_release_w) begin
        state_d = ENV_RELEASE;
      end else begin
        unique case (state_q)
          ENV_IDLE: begin
            acc_d = '0;
          end
          ENV_ATTACK: begin
            if (att_sum_w >= {1'b0, ACC_MAX}) begin
              acc_d   = ACC_MAX;
              state_d = ENV_DECAY;
            end else begin
              acc_d = att_sum_w[ACC_BITS-1:0];
            end
          end
          ENV_DECAY: begin
            if (dec_diff_w <= $signed({1'b0, sus_w})) begin
              acc_d   = sus_w;
              state_d = oneshot_i ? ENV_RELEASE : ENV_SUSTAIN;
            end else begin
              acc_d = dec_diff_w[ACC_BITS-1:0];
            end
          end
          ENV_SUSTAIN: begin
            acc_d = sus_w;
          end
          ENV_RELEASE: begin
            if (acc_q <= release_step_i) begin
              acc_d   = '0;
              state_d = ENV_IDLE;
              done_d  = 1'b1;
            end else begin
              acc_d = acc_q - release_step_i;
            end
          end
          default: begin
            acc_d   = '0;
            state_d = ENV_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ENV_IDLE;
      acc_q       <= '0;
      gate_prev_q <= 1'b0;
      pend_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      gate_prev_q <= gate_prev_d;
      pend_q      <= pend_d;
      done_q      <= done_d;
    end
  end

  assign vol_o    = acc_q[ACC_BITS-1 -: VOLUME_BITS];
  assign active_o = (state_q != ENV_IDLE);
  assign done_o   = done_q;

endmodule

// File: rtl/adsr_envelope_multi.sv
// Multi-channel ADSR envelope generator: NUM_CH independent voices sharing one
// attack/decay/sustain/release configuration.
module adsr_envelope_multi
  import env_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ACC_BITS    = 24,
  parameter int VOLUME_BITS = 8
) (
  input  logic                          mclk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [NUM_CH-1:0]             gate,
  input  logic                          oneshot,
  input  logic [ACC_BITS-1:0]           attack_step,
  input  logic [ACC_BITS-1:0]           decay_step,
  input  logic [ACC_BITS-1:0]           release_step,
  input  logic [VOLUME_BITS-1:0]        sustain_level,
  output logic [NUM_CH*VOLUME_BITS-1:0] vol_out,
  output logic [NUM_CH-1:0]             active,
  output logic [NUM_CH-1:0]             done
);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    env_channel #(
      .ACC_BITS    (ACC_BITS),
      .VOLUME_BITS (VOLUME_BITS)
    ) u_env_channel (
      .clk_i           (mclk),
      .rst_i           (rst),
      .tick_i          (tick),
      .gate_i          (gate[ch]),
      .oneshot_i       (oneshot),
      .attack_step_i   (attack_step),
      .decay_step_i    (decay_step),
      .release_step_i  (release_step),
      .sustain_level_i (sustain_level),
      .vol_o           (vol_out[ch*VOLUME_BITS +: VOLUME_BITS]),
      .active_o        (active[ch]),
      .done_o          (done[ch])
    );
  end

endmodule
